spi_flash_responder: RTL and testbench

SPI_FLASH_RESPONDER -- requirements
Module: spi_flash_responder

---
 rtl/spi_flash_responder_if.sv | 21 ++
 rtl/spi_flash_responder.sv | 193 +++++++++++++++++++
 tb/tb_spi_flash_responder.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/spi_flash_responder_if.sv
// SPI pins and backing-store read port of the flash responder, bundled for the top-level ports.
interface spi_flash_responder_if;
  logic        S;
  logic        C;
  logic        DQ0;
  logic        DQ1_o;
  logic        DQ1_oe;
  logic [23:0] mem_addr;
  logic        mem_rd;
  logic [7:0]  mem_rdata;
  logic        busy;

  modport slave (
    input  S, C, DQ0, mem_rdata,
    output DQ1_o, DQ1_oe, mem_addr, mem_rd, busy
  );
  modport master (
    output S, C, DQ0, mem_rdata,
    input  DQ1_o, DQ1_oe, mem_addr, mem_rd, busy
  );
endinterface

// File: rtl/spi_flash_responder.sv
// SPI mode-0 serial flash target: READ / RDSR / RDID / WREN / WRDI over an oversampled SPI bus.
module spi_flash_responder #(
  parameter logic [23:0] ID_WORD     = 24'h20BA18,
  parameter int          SYNC_STAGES = 2
) (
  input  logic                 CLK_100M,
  input  logic                 rst_n,
  spi_flash_responder_if.slave bus
);
  typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, STATUS, ID, IGNORE} state_e;
  localparam int LS = SYNC_STAGES - 1;

  state_e      state_q, state_d;
  logic [LS:0] s_sync_q, s_sync_d, c_sync_q, c_sync_d, d_sync_q, d_sync_d, vld_q, vld_d;
  logic        s_prev_q, s_prev_d, c_prev_q, c_prev_d, armed_q, armed_d;
  logic [4:0]  bit_cnt_q, bit_cnt_d;
  logic [22:0] sh_q, sh_d;
  logic [23:0] mem_addr_q, mem_addr_d;
  logic [7:0]  tx_q, tx_d, data_q, data_d;
  logic [1:0]  id_idx_q, id_idx_d;
  logic        wel_q, wel_d, dq1_q, dq1_d, mem_rd_q, mem_rd_d, rd_pend_q, rd_pend_d;

  logic       s_s, c_s, d_s, s_fall, s_rise, c_rise, c_fall, cmd_done, addr_done;
  logic [7:0] opc, out_byte;

  // Synchronizers; vld tracks when the chain holds real pin samples rather than reset values.
  always_comb begin
    s_sync_d  = {s_sync_q[LS-1:0], bus.S};
    c_sync_d  = {c_sync_q[LS-1:0], bus.C};
    d_sync_d  = {d_sync_q[LS-1:0], bus.DQ0};
    vld_d     = {vld_q[LS-1:0], 1'b1};
    s_s       = s_sync_q[LS];
    c_s       = c_sync_q[LS];
    d_s       = d_sync_q[LS];
    s_prev_d  = s_s;
    c_prev_d  = c_s;
    // A transaction may only start once S has genuinely been seen high after reset.
    armed_d   = armed_q | (vld_q[LS] & s_s);
    s_fall    = armed_q & s_prev_q & ~s_s;
    s_rise    = ~s_prev_q & s_s;
    c_rise    = c_s & ~c_prev_q;
    c_fall    = ~c_s & c_prev_q;
    opc       = {sh_q[6:0], d_s};
    cmd_done  = (state_q == CMD)  && c_rise && (bit_cnt_q == 5'd7);
    addr_done = (state_q == ADDR) && c_rise && (bit_cnt_q == 5'd23);
  end

  always_ff @(posedge CLK_100M) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (s_rise) state_d = IDLE;
    else begin
      case (state_q)
        IDLE: if (s_fall) state_d = CMD;
        CMD:
          if (cmd_done) begin
            case (opc)
              8'h03:   state_d = ADDR;
              8'h05:   state_d = STATUS;
              8'h9F:   state_d = ID;
              default: state_d = IGNORE;
            endcase
          end
        ADDR: if (addr_done) state_d = DATA;
        default: ;
      endcase
    end
  end

  always_comb begin
    case (state_q)
      DATA:    out_byte = data_q;
      STATUS:  out_byte = {6'b0, wel_q, 1'b0};
      ID: begin
        case (id_idx_q)
          2'd0:    out_byte = ID_WORD[23:16];
          2'd1:    out_byte = ID_WORD[15:8];
          2'd2:    out_byte = ID_WORD[7:0];
          default: out_byte = 8'h00;
        endcase
      end
      default: out_byte = 8'h00;
    endcase
  end

  always_comb begin
    bit_cnt_d  = bit_cnt_q;
    sh_d       = sh_q;
    tx_d       = tx_q;
    id_idx_d   = id_idx_q;
    wel_d      = wel_q;
    dq1_d      = dq1_q;
    mem_addr_d = mem_addr_q;
    mem_rd_d   = 1'b0;
    rd_pend_d  = mem_rd_q;
    data_d     = rd_pend_q ? bus.mem_rdata : data_q;
    if (s_rise) begin
      bit_cnt_d = '0;
      sh_d      = '0;
    end else begin
      case (state_q)
        IDLE:
          if (s_fall) begin
            bit_cnt_d = '0;
            id_idx_d  = '0;
          end
        CMD, ADDR:
          if (c_rise) begin
            sh_d      = {sh_q[21:0], d_s};
            bit_cnt_d = bit_cnt_q + 5'd1;
            if (cmd_done) begin
              bit_cnt_d = '0;
              if (opc == 8'h06)      wel_d = 1'b1;
              else if (opc == 8'h04) wel_d = 1'b0;
            end
            if (addr_done) begin
              bit_cnt_d  = '0;
              mem_addr_d = {sh_q[22:0], d_s};
              mem_rd_d   = 1'b1;
            end
          end
        DATA, STATUS, ID:
          if (c_fall) begin
            bit_cnt_d = {2'b00, bit_cnt_q[2:0] + 3'd1};
            if (bit_cnt_q[2:0] == 3'd0) begin
              // MSB goes out now; the rest of the byte is parked in tx so data_q can take the prefetch.
              dq1_d = out_byte[7];
              tx_d  = {out_byte[6:0], 1'b0};
              if (state_q == DATA) begin
                mem_addr_d = mem_addr_q + 24'd1;
                mem_rd_d   = 1'b1;
              end
              if (state_q == ID && id_idx_q != 2'd3) id_idx_d = id_idx_q + 2'd1;
            end else begin
              dq1_d = tx_q[7];
              tx_d  = {tx_q[6:0], 1'b0};
            end
          end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK_100M) begin
    if (!rst_n) begin
      s_sync_q   <= '1;
      c_sync_q   <= '0;
      d_sync_q   <= '0;
      vld_q      <= '0;
      s_prev_q   <= 1'b1;
      c_prev_q   <= 1'b0;
      armed_q    <= 1'b0;
      bit_cnt_q  <= '0;
      sh_q       <= '0;
      tx_q       <= '0;
      data_q     <= '0;
      id_idx_q   <= '0;
      wel_q      <= 1'b0;
      dq1_q      <= 1'b0;
      mem_addr_q <= '0;
      mem_rd_q   <= 1'b0;
      rd_pend_q  <= 1'b0;
    end else begin
      s_sync_q   <= s_sync_d;
      c_sync_q   <= c_sync_d;
      d_sync_q   <= d_sync_d;
      vld_q      <= vld_d;
      s_prev_q   <= s_prev_d;
      c_prev_q   <= c_prev_d;
      armed_q    <= armed_d;
      bit_cnt_q  <= bit_cnt_d;
      sh_q       <= sh_d;
      tx_q       <= tx_d;
      data_q     <= data_d;
      id_idx_q   <= id_idx_d;
      wel_q      <= wel_d;
      dq1_q      <= dq1_d;
      mem_addr_q <= mem_addr_d;
      mem_rd_q   <= mem_rd_d;
      rd_pend_q  <= rd_pend_d;
    end
  end

  assign bus.DQ1_o    = dq1_q;
  assign bus.DQ1_oe   = (state_q == DATA) || (state_q == STATUS) || (state_q == ID);
  assign bus.mem_addr = mem_addr_q;
  assign bus.mem_rd   = mem_rd_q;
  assign bus.busy     = ~s_s;
endmodule

// File: tb/tb_spi_flash_responder.sv
// Randomized scoreboard bench for spi_flash_responder: SPI master driver, byte/mem-read monitors, flash model.
module tb_spi_flash_responder;
  localparam logic [23:0] IDW = 24'h20BA18;
  localparam int HP = 60;

  logic CLK_100M = 1'b0;
  logic rst_n    = 1'b0;
  spi_flash_responder_if bus();

  spi_flash_responder #(.ID_WORD(IDW), .SYNC_STAGES(2)) dut (
    .CLK_100M(CLK_100M), .rst_n(rst_n), .bus(bus.slave)
  );

  always #5 CLK_100M = ~CLK_100M;

  int         vectors = 0, errors = 0;
  logic [7:0] exp_q[$];
  logic [23:0] addr_exp_q[$];
  bit         mon_en = 1'b0;
  int         mon_nb = 0;
  logic [7:0] mon_cur = 8'h00;
  bit         wel = 1'b0;

  function automatic logic [7:0] store(input logic [23:0] a);
    return a[7:0] ^ a[23:16];
  endfunction

  // Backing store: data valid the cycle after the strobe, junk otherwise.
  always @(posedge CLK_100M)
    bus.mem_rdata <= bus.mem_rd ? store(bus.mem_addr) : 8'($urandom);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Byte monitor: bits the DUT actually drives (oe high) are assembled MSB first and scored.
  always @(posedge bus.C) begin
    if (mon_en && !bus.S && bus.DQ1_oe) begin
      mon_cur = {mon_cur[6:0], bus.DQ1_o};
      mon_nb++;
      if (mon_nb == 8) begin
        mon_nb = 0;
        if (exp_q.size() == 0) begin
          vectors++; errors++;
          $display("FAIL extra_byte: got %0h expected none", mon_cur);
        end else chk("dq1_byte", 32'(mon_cur), 32'(exp_q.pop_front()));
      end
    end
  end

  always @(posedge bus.S) if (mon_en) chk("partial_bits", 32'(mon_nb), 32'd0);

  always @(negedge CLK_100M) begin
    if (mon_en && bus.mem_rd) begin
      if (addr_exp_q.size() == 0) begin
        vectors++; errors++;
        $display("FAIL unexpected_mem_rd: got addr %0h expected none", bus.mem_addr);
      end else chk("mem_addr", 32'(bus.mem_addr), 32'(addr_exp_q.pop_front()));
    end
  end

  task automatic send_bit(input logic b);
    bus.DQ0 = b; #HP bus.C = 1'b1; #HP bus.C = 1'b0;
  endtask

  task automatic run_txn(input logic [7:0] op, input int nop, input logic [23:0] addr,
                         input int na, input int nt, input bit c_hi);
    logic q[$];
    for (int i = 0; i < nop; i++) q.push_back(op[7-i]);
    for (int i = 0; i < na; i++)  q.push_back(addr[23-i]);
    for (int i = 0; i < nt; i++)  q.push_back(1'($urandom));
    if (c_hi) begin bus.C = 1'b1; #30; end
    bus.S = 1'b0; #40;
    if (c_hi) begin bus.C = 1'b0; #40; end
    chk("busy_hi", 32'(bus.busy), 32'd1);
    for (int i = 0; i < q.size(); i++) begin
      bus.DQ0 = q[i]; #HP bus.C = 1'b1; #HP;
      if (i == q.size() - 1) begin bus.S = 1'b1; #20; end
      bus.C = 1'b0;
    end
    #150;
    chk("busy_lo", 32'(bus.busy), 32'd0);
    chk("bytes_left", 32'(exp_q.size()), 32'd0);
    chk("rd_left", 32'(addr_exp_q.size()), 32'd0);
    exp_q.delete();
    addr_exp_q.delete();
  endtask

  task automatic do_read(input logic [23:0] a, input int n);
    for (int k = 0; k < n; k++)  exp_q.push_back(store(a + 24'(k)));
    for (int k = 0; k <= n; k++) addr_exp_q.push_back(a + 24'(k));
    run_txn(8'h03, 8, a, 24, 8 * n, 1'b0);
  endtask

  task automatic do_status(input int n);
    for (int k = 0; k < n; k++) exp_q.push_back({6'b0, wel, 1'b0});
    run_txn(8'h05, 8, 24'h0, 0, 8 * n, 1'b0);
  endtask

  task automatic do_id(input int n, input bit c_hi);
    for (int k = 0; k < n; k++)
      exp_q.push_back(k == 0 ? IDW[23:16] : k == 1 ? IDW[15:8] : k == 2 ? IDW[7:0] : 8'h00);
    run_txn(8'h9F, 8, 24'h0, 0, 8 * n, c_hi);
  endtask

  task automatic do_wr(input logic [7:0] op);
    wel = (op == 8'h06);
    run_txn(op, 8, 24'h0, 0, int'($urandom_range(0, 12)), 1'b0);
  endtask

  task automatic do_other();
    logic [7:0] op;
    do op = 8'($urandom); while (op inside {8'h03, 8'h05, 8'h9F, 8'h06, 8'h04});
    run_txn(op, 8, 24'h0, 0, int'($urandom_range(0, 16)), 1'b0);
  endtask

  task automatic reset_in_data();
    logic [23:0] a;
    a = 24'($urandom);
    mon_en = 1'b0;
    bus.S = 1'b0; #40;
    for (int i = 7; i >= 0; i--)  send_bit(1'(8'h03 >> i));
    for (int i = 23; i >= 0; i--) send_bit(a[i]);
    for (int i = 0; i < 3; i++)   send_bit(1'($urandom));
    bus.DQ0 = 1'b1; #HP bus.C = 1'b1; #20;
    @(posedge CLK_100M); #1 rst_n = 1'b0;
    @(posedge CLK_100M); #1;
    chk("rst_data_oe", 32'(bus.DQ1_oe), 32'd0);
    chk("rst_data_rd", 32'(bus.mem_rd), 32'd0);
    chk("rst_data_dq1", 32'(bus.DQ1_o), 32'd0);
    chk("rst_data_addr", 32'(bus.mem_addr), 32'd0);
    rst_n = 1'b1;
    wel = 1'b0;
    exp_q.delete(); addr_exp_q.delete();
    mon_nb = 0;
    mon_en = 1'b1;
    #40 bus.C = 1'b0;
    // S never went high since reset, so this RDID must be ignored entirely.
    for (int i = 7; i >= 0; i--) send_bit(1'(8'h9F >> i));
    for (int i = 0; i < 16; i++) send_bit(1'($urandom));
    chk("unarmed_oe", 32'(bus.DQ1_oe), 32'd0);
    bus.S = 1'b1; #150;
  endtask

  initial begin
    bus.S = 1'b1; bus.C = 1'b0; bus.DQ0 = 1'b0;
    rst_n = 1'b0;
    repeat (4) @(posedge CLK_100M);
    #1;
    chk("reset_oe", 32'(bus.DQ1_oe), 32'd0);
    chk("reset_dq1", 32'(bus.DQ1_o), 32'd0);
    chk("reset_rd", 32'(bus.mem_rd), 32'd0);
    chk("reset_addr", 32'(bus.mem_addr), 32'd0);
    chk("reset_busy", 32'(bus.busy), 32'd0);
    rst_n = 1'b1;
    #100;
    mon_en = 1'b1;

    do_id(3, 1'b0);
    do_id(5, 1'b0);
    do_read(24'h000010, 3);
    do_read(24'hFFFFFF, 2);
    do_status(1);
    do_wr(8'h06);
    do_status(3);
    do_wr(8'h04);
    do_status(1);
    run_txn(8'h03, 8, 24'h123456, 12, 0, 1'b0);
    do_id(4, 1'b0);
    run_txn(8'h9F, 5, 24'h0, 0, 0, 1'b0);
    do_id(3, 1'b1);
    do_other();
    do_wr(8'h06);
    reset_in_data();
    do_status(2);

    for (int t = 0; t < 25; t++) begin
      case ($urandom_range(0, 7))
        0, 1: do_read(($urandom_range(0, 3) == 0) ? 24'hFFFFFF - 24'($urandom_range(0, 2))
                                                   : 24'($urandom), int'($urandom_range(1, 4)));
        2: do_status(int'($urandom_range(1, 3)));
        3: do_id(int'($urandom_range(1, 5)), 1'($urandom_range(0, 1)));
        4: do_wr($urandom_range(0, 1) == 1 ? 8'h06 : 8'h04);
        5: do_other();
        6: run_txn(8'h03, 8, 24'($urandom), int'($urandom_range(0, 23)), 0, 1'b0);
        default: run_txn(8'($urandom), int'($urandom_range(1, 7)), 24'h0, 0, 0, 1'b0);
      endcase
    end
    do_status(1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
